// File: rtl/life_pkg.sv
// Shared Game-of-Life grid geometry, plot colours and render FSM encoding.
package life_pkg;

  localparam int GRID_W = 160;
  localparam int GRID_H = 120;
  localparam int X_W    = 8;
  localparam int Y_W    = 7;

  localparam logic [2:0] ALIVE_COLOUR = 3'b111;
  localparam logic [2:0] DEAD_COLOUR  = 3'b000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } render_state_t;

endpackage

// File: rtl/grid_renderer_raster_counter.sv
// Raster-order x/y cell counter: x fastest, wraps at W-1/H-1, flags the final cell.
module raster_counter
  import life_pkg::*;
#(
  parameter int W  = GRID_W,
  parameter int H  = GRID_H,
  parameter int XW = X_W,
  parameter int YW = Y_W
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          enable,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  localparam logic [XW-1:0] X_MAX = XW'(W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(H - 1);

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      x <= '0;
      y <= '0;
    end else if (enable) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= (y == Y_MAX) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign last = (x == X_MAX) && (y == Y_MAX);

endmodule

// File: rtl/grid_renderer.sv
// Scans the cell store in raster order and emits one VGA plot per cell.
// Optional GRID_RENDER_DIFF_EN: plot only cells whose value differs from cell_prev_data.
module grid_renderer
  import life_pkg::*;
(
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  output logic           cell_rd_en,
  output logic [X_W-1:0] cell_x,
  output logic [Y_W-1:0] cell_y,
  input  logic           cell_rd_data,
`ifdef GRID_RENDER_DIFF_EN
  input  logic           cell_prev_data,
`endif
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [2:0]     vga_colour,
  output logic           vga_plot,
  output logic           busy,
  output logic           done
);

  render_state_t state_q, state_d;
  logic          scan_last;
  logic          rd_valid;
  logic [X_W-1:0] x_d1;
  logic [Y_W-1:0] y_d1;
  logic          plot_d;

  raster_counter u_scan (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state_q == IDLE),
    .enable  (state_q == SCAN),
    .x       (cell_x),
    .y       (cell_y),
    .last    (scan_last)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (scan_last) state_d = DRAIN;
      DRAIN:   state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cell_rd_en = (state_q == SCAN);
  assign busy       = (state_q != IDLE);

`ifdef GRID_RENDER_DIFF_EN
  assign plot_d = rd_valid && (cell_rd_data != cell_prev_data);
`else
  assign plot_d = rd_valid;
`endif

  // done is registered so it lands the cycle after the final plot leaves the pipe.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_valid   <= 1'b0;
      x_d1       <= '0;
      y_d1       <= '0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= DEAD_COLOUR;
      done       <= 1'b0;
    end else begin
      rd_valid <= cell_rd_en;
      x_d1     <= cell_x;
      y_d1     <= cell_y;
      vga_plot <= plot_d;
      done     <= (state_q == FIN);
      if (plot_d) begin
        vga_x      <= x_d1;
        vga_y      <= y_d1;
        vga_colour <= cell_rd_data ? ALIVE_COLOUR : DEAD_COLOUR;
      end
    end
  end

endmodule

// File: doc/grid_renderer.md
Name: grid_renderer

Overview:
Reads the 160x120 Game-of-Life cell store in raster order and emits one VGA-adapter plot per cell: x, y, colour and a plot strobe. It is the read side of the cell array; the datapath owns and updates the cells, and this block only consumes them. It sits between the cell store and the vga_adapter instance in main and is kicked once per generation by the control FSM.

Parameters:
GRID_W, 160, cells per row; x range 0..GRID_W-1, must be <= 256.
GRID_H, 120, rows; y range 0..GRID_H-1, must be <= 128.
ALIVE_COLOUR, 3'b111, colour plotted for a cell = 1.
DEAD_COLOUR, 3'b000, colour plotted for a cell = 0.

Ports:
clock  in  1  system clock (CLOCK_50).
reset_n  in  1  reset; synchronous, active-low.
start  in  1  one-cycle request to render a full frame; sampled only in IDLE.
cell_rd_en  out  1  read strobe to the cell store.
cell_x  out  8  cell column being read.
cell_y  out  7  cell row being read.
cell_rd_data  in  1  cell value; valid exactly 1 cycle after cell_rd_en.
vga_x  out  8  plot x to the adapter.
vga_y  out  7  plot y to the adapter.
vga_colour  out  3  plot colour.
vga_plot  out  1  adapter writeEn; one pixel per high cycle.
busy  out  1  high from start acceptance until done.
done  out  1  one-cycle pulse after the last plot.

Behaviour:
- Reset values: all outputs 0, state IDLE, scan counters 0.
- States:
  - IDLE: start=1 moves to SCAN next cycle, with counters at (0,0).
  - SCAN: every cycle, cell_rd_en=1 with cell_x/cell_y = counters. x increments fastest.
    - When x = GRID_W-1: x wraps to 0 and y increments.
    - After issuing (GRID_W-1, GRID_H-1): go to DRAIN.
  - DRAIN: one cycle, cell_rd_en=0, lets the final read return; then go to FIN.
  - FIN: done=1 for exactly one cycle, then IDLE.
- Pipeline: address issued in cycle k, data in k+1, registered plot outputs visible in k+2.
  - vga_x/vga_y are a 2-stage delayed copy of cell_x/cell_y.
  - vga_colour = cell_rd_data ? ALIVE_COLOUR : DEAD_COLOUR.
- Timing:
  - First vga_plot occurs 3 cycles after the start-accept edge (IDLE -> SCAN at edge 1, first read cycle, data cycle, plot visible).
  - Exactly GRID_W*GRID_H (19200) plots per frame, contiguous, no gaps.
  - The last plot and the done pulse are in consecutive cycles.
- busy: high in SCAN, DRAIN and FIN, low only in IDLE.
- start while busy: ignored; no queuing.
- reset_n low mid-frame: on the next edge, state = IDLE, vga_plot = 0, cell_rd_en = 0, done = 0. Pipeline contents are discarded and no partial plot is emitted.
- start and reset_n=0 in the same cycle: reset wins.
- vga_x/vga_y/vga_colour hold their last value when vga_plot=0; consumers must qualify on vga_plot.

Optional Feature:
Macro GRID_RENDER_DIFF_EN.
- Defined:
  - Adds input port cell_prev_data (1 bit), with the same timing as cell_rd_data.
  - vga_plot is asserted only when cell_rd_data != cell_prev_data. Pipeline, scan length and done timing are unchanged.
- Undefined: port absent; every cell is plotted.

Decomposition:
- Package life_pkg holds:
  - GRID_W and GRID_H
  - the ALIVE/DEAD colour constants
  - X_W=8 and Y_W=7
  - the render state enum (IDLE, SCAN, DRAIN, FIN)
- One sub-module, raster_counter: x/y counter with enable, wrap and a last flag. The same counter is reusable by the generation-update engine.

Test Plan:
- Reset, then a start pulse with a store holding only column 50 alive -> 19200 plots. Colour 3'b111 exactly where vga_x=50 (120 plots); all other plots 3'b000. done pulses once, the cycle after the plot at (159,119).
- Start pulse -> cell_rd_en rises the next cycle at (0,0). The first vga_plot is 3 cycles after the start edge, with vga_x=0, vga_y=0. Row wrap: plot (159,0) is followed immediately by (0,1).
- Second start pulse 100 cycles into a frame -> ignored. Total plots = 19200, a single done pulse, busy stays high throughout.
- reset_n=0 at plot 5000 -> next cycle vga_plot=0, busy=0, done never asserts. A new start then renders a full 19200-plot frame from (0,0).
- start=1 and reset_n=0 in the same cycle -> remains IDLE, no cell_rd_en.
- With GRID_RENDER_DIFF_EN defined: prev = all 0, cur = only cell (10,20) = 1 -> exactly one plot, at (10,20) with colour 3'b111. done timing is identical to the undefined build.
